ps2_keycode_receiver: RTL and testbench

- Receives device-to-host PS/2 frames from the keyboard (KClock/KData) and produces the KeyCode/Flag interface that the decoder/synth consumes.
- Synchronizes and deglitches the PS/2 lines, then shifts in 11-bit frames and checks parity and the stop bit.
- Tracks the E0 (extended) and F0 (break) prefixes.
- Presents each completed scan code with a one-cycle Flag strobe.

---
 rtl/ps2_keycode_receiver.sv | 151 +++++++++++++++
 tb/tb_ps2_keycode_receiver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_receiver.sv
// rtl/ps2_keycode_receiver.sv - PS/2 device-to-host frame receiver with E0/F0 prefix tracking
module ps2_keycode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       Clock,
    input  logic       btnCpuReset,
    input  logic       KClock,
    input  logic       KData,
    output logic [7:0] KeyCode,
    output logic       Flag,
    output logic       Released,
    output logic       Extended,
    output logic       ParityErr
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkFilt;
    logic [FW-1:0] filtCnt;
    logic          fe;
    logic          kdat;

    state_t        state;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] timeoutCnt;
    logic          extLatch;
    logic          brkLatch;
    logic          frameOk;

    assign kdat    = dataSync[1];
    assign frameOk = kdat && ((^shiftReg) ^ parityBit);

    // Lines idle high, so the synchronizers reset to 1 to avoid a false edge
    always_ff @(posedge Clock or posedge btnCpuReset) begin
        if (btnCpuReset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], KClock};
            dataSync <= {dataSync[0], KData};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge Clock or posedge btnCpuReset) begin
        if (btnCpuReset) begin
            clkFilt <= 1'b1;
            filtCnt <= '0;
            fe      <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clkSync[1] != clkFilt) begin
                if (filtCnt == FW'(FILTER_LEN - 1)) begin
                    clkFilt <= clkSync[1];
                    filtCnt <= '0;
                    fe      <= clkFilt;
                end else begin
                    filtCnt <= filtCnt + 1'b1;
                end
            end else begin
                filtCnt <= '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge btnCpuReset) begin
        if (btnCpuReset) begin
            state      <= IDLE;
            bitCnt     <= '0;
            shiftReg   <= '0;
            parityBit  <= 1'b0;
            timeoutCnt <= '0;
            extLatch   <= 1'b0;
            brkLatch   <= 1'b0;
            KeyCode    <= '0;
            Flag       <= 1'b0;
            Released   <= 1'b0;
            Extended   <= 1'b0;
            ParityErr  <= 1'b0;
        end else begin
            Flag      <= 1'b0;
            ParityErr <= 1'b0;
            if (fe) begin
                timeoutCnt <= '0;
                case (state)
                    IDLE: begin
                        if (!kdat) begin
                            state  <= DATA;
                            bitCnt <= '0;
                        end else begin
                            ParityErr <= 1'b1;
                        end
                    end
                    DATA: begin
                        shiftReg <= {kdat, shiftReg[7:1]};
                        if (bitCnt == 3'd7) begin
                            state  <= PARITY;
                            bitCnt <= '0;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        parityBit <= kdat;
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frameOk) begin
                            ParityErr <= 1'b1;
                            extLatch  <= 1'b0;
                            brkLatch  <= 1'b0;
                        end else if (shiftReg == 8'hE0) begin
                            extLatch <= 1'b1;
                        end else if (shiftReg == 8'hF0) begin
                            brkLatch <= 1'b1;
                        end else begin
                            KeyCode  <= shiftReg;
                            Released <= brkLatch;
                            Extended <= extLatch;
                            Flag     <= 1'b1;
                            extLatch <= 1'b0;
                            brkLatch <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled keyboard must not leave half a frame or stale prefixes behind
                if (timeoutCnt == TW'(TIMEOUT_CYCLES)) begin
                    state      <= IDLE;
                    bitCnt     <= '0;
                    timeoutCnt <= '0;
                    extLatch   <= 1'b0;
                    brkLatch   <= 1'b0;
                end else begin
                    timeoutCnt <= timeoutCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// tb/tb_ps2_keycode_receiver.sv - randomized self-checking bench for ps2_keycode_receiver
module tb_ps2_keycode_receiver;

    localparam int FLEN    = 4;
    localparam int TOUT    = 200;
    localparam int LATENCY = 2 + FLEN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kClock = 1'b1;
    logic       kData = 1'b1;
    logic [7:0] KeyCode;
    logic       Flag, Released, Extended, ParityErr;

    ps2_keycode_receiver #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .Clock(clk), .btnCpuReset(rst), .KClock(kClock), .KData(kData),
        .KeyCode(KeyCode), .Flag(Flag), .Released(Released),
        .Extended(Extended), .ParityErr(ParityErr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int flagPulses = 0, flagHigh = 0, flagCyc = 0;
    int perrPulses = 0, perrHigh = 0;
    logic flagPrev = 1'b0, perrPrev = 1'b0;
    always @(negedge clk) begin
        if (Flag) begin
            flagHigh++;
            if (!flagPrev) begin
                flagPulses++;
                flagCyc = cyc;
            end
        end
        if (ParityErr) begin
            perrHigh++;
            if (!perrPrev) perrPulses++;
        end
        flagPrev = Flag;
        perrPrev = ParityErr;
    end

    // Reference model: keyboard protocol at byte level
    int         expFlags = 0, expPerrs = 0;
    bit         mExt = 0, mBrk = 0, mRel = 0, mExtOut = 0;
    logic [7:0] mKey = 8'h00;
    bit         lastFlagged = 0;
    int         stopFallCyc = 0;

    task automatic sendBit(input logic v);
        @(negedge clk) kData = v;
        repeat (10) @(negedge clk);
        kClock = 1'b0;
        stopFallCyc = cyc;
        repeat (20) @(negedge clk);
        kClock = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit parOk, input bit stopOk);
        logic [10:0] bits;
        bits = {stopOk ? 1'b1 : 1'b0, parOk ? ~(^b) : (^b), b, 1'b0};
        for (int i = 0; i < 11; i++) sendBit(bits[i]);
        repeat (20) @(negedge clk);
        lastFlagged = 0;
        if (!(parOk && stopOk)) begin
            expPerrs++;
            mExt = 0;
            mBrk = 0;
        end else if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else begin
            expFlags++;
            mKey = b;
            mRel = mBrk;
            mExtOut = mExt;
            mExt = 0;
            mBrk = 0;
            lastFlagged = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({KeyCode, Flag, Released, Extended, ParityErr} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 000", {KeyCode, Flag, Released, Extended, ParityErr});
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        sendFrame(8'h24, 1, 1);
        vectors++;
        if (flagPulses !== expFlags) begin
            miscompares++; $display("FAIL basic_flag_count got %0d exp %0d", flagPulses, expFlags);
        end
        vectors++;
        if (flagCyc - stopFallCyc !== LATENCY) begin
            miscompares++; $display("FAIL basic_latency got %0d exp %0d", flagCyc - stopFallCyc, LATENCY);
        end
        vectors++;
        if (flagHigh !== flagPulses) begin
            miscompares++; $display("FAIL basic_flag_width got %0d exp %0d", flagHigh, flagPulses);
        end
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || perrPulses !== expPerrs) begin
            miscompares++;
            $display("FAIL basic_outputs got %h/%0d exp %h/%0d", {KeyCode, Released, Extended}, perrPulses, {mKey, mRel, mExtOut}, expPerrs);
        end
    endtask

    task automatic test_prefixes();
        sendFrame(8'hF0, 1, 1);
        vectors++;
        if (flagPulses !== expFlags) begin
            miscompares++; $display("FAIL break_prefix_no_flag got %0d exp %0d", flagPulses, expFlags);
        end
        sendFrame(8'h0D, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL break_0d got %h exp %h", {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
        end
        sendFrame(8'h1C, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut}) begin
            miscompares++; $display("FAIL make_1c got %h exp %h", {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
        end
        sendFrame(8'hE0, 1, 1);
        sendFrame(8'hF0, 1, 1);
        sendFrame(8'hF0, 1, 1);
        sendFrame(8'h75, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL ext_break_75 got %h/%0d exp %h/%0d", {KeyCode, Released, Extended}, flagPulses, {mKey, mRel, mExtOut}, expFlags);
        end
    endtask

    task automatic test_parity_error();
        sendFrame(8'h24, 0, 1);
        vectors++;
        if (perrPulses !== expPerrs || perrHigh !== perrPulses || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL bad_parity got perr %0d/%0d flag %0d exp %0d/%0d", perrPulses, perrHigh, flagPulses, expPerrs, expFlags);
        end
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut}) begin
            miscompares++; $display("FAIL bad_parity_hold got %h exp %h", {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
        end
        sendFrame(8'h33, 1, 0);
        vectors++;
        if (perrPulses !== expPerrs || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL bad_stop got perr %0d flag %0d exp %0d/%0d", perrPulses, flagPulses, expPerrs, expFlags);
        end
        sendBit(1'b1);
        repeat (20) @(negedge clk);
        expPerrs++;
        vectors++;
        if (perrPulses !== expPerrs) begin
            miscompares++; $display("FAIL bad_start got %0d exp %0d", perrPulses, expPerrs);
        end
        sendFrame(8'h1C, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL after_error_1c got %h exp %h", {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
        end
    endtask

    task automatic test_timeout();
        sendFrame(8'hF0, 1, 1);
        for (int i = 0; i < 5; i++) sendBit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
        repeat (TOUT + 10) @(negedge clk);
        mExt = 0;
        mBrk = 0;
        vectors++;
        if (flagPulses !== expFlags || perrPulses !== expPerrs) begin
            miscompares++; $display("FAIL timeout_silent got flag %0d perr %0d exp %0d/%0d", flagPulses, perrPulses, expFlags, expPerrs);
        end
        sendFrame(8'h1C, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL timeout_then_1c got %h exp %h", {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
        end
    endtask

    task automatic test_glitch_reset();
        @(negedge clk) kClock = 1'b0;
        repeat (2) @(negedge clk);
        kClock = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (perrPulses !== expPerrs || flagPulses !== expFlags) begin
            miscompares++; $display("FAIL glitch got perr %0d flag %0d exp %0d/%0d", perrPulses, flagPulses, expPerrs, expFlags);
        end
        sendFrame(8'hE0, 1, 1);
        sendFrame(8'hF0, 1, 1);
        for (int i = 0; i < 4; i++) sendBit(i == 0 ? 1'b0 : 1'b1);
        @(negedge clk) kClock = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({KeyCode, Flag, Released, Extended, ParityErr} !== 12'h000) begin
            miscompares++; $display("FAIL midframe_reset got %h exp 000", {KeyCode, Flag, Released, Extended, ParityErr});
        end
        kClock = 1'b1;
        kData = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        mExt = 0; mBrk = 0; mKey = 8'h00; mRel = 0; mExtOut = 0;
        repeat (10) @(negedge clk);
        sendFrame(8'h24, 1, 1);
        vectors++;
        if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut} || flagPulses !== expFlags || perrPulses !== expPerrs) begin
            miscompares++; $display("FAIL after_reset_24 got %h/%0d/%0d exp %h/%0d/%0d", {KeyCode, Released, Extended}, flagPulses, perrPulses, {mKey, mRel, mExtOut}, expFlags, expPerrs);
        end
    endtask

    task automatic test_random();
        logic [7:0] code;
        int pre;
        for (int n = 0; n < 24; n++) begin
            pre  = $urandom_range(0, 3);
            code = 8'($urandom_range(0, 255));
            if (code == 8'hE0 || code == 8'hF0) code = code ^ 8'h01;
            if (pre[1]) sendFrame(8'hE0, 1, 1);
            if (pre[0]) sendFrame(8'hF0, 1, 1);
            sendFrame(code, $urandom_range(0, 5) != 0, $urandom_range(0, 9) != 0);
            vectors++;
            if (flagPulses !== expFlags || perrPulses !== expPerrs || flagHigh !== flagPulses) begin
                miscompares++; $display("FAIL rand%0d_counts got flag %0d/%0d perr %0d exp %0d/%0d", n, flagPulses, flagHigh, perrPulses, expFlags, expPerrs);
            end
            vectors++;
            if ({KeyCode, Released, Extended} !== {mKey, mRel, mExtOut}) begin
                miscompares++; $display("FAIL rand%0d_outputs got %h exp %h", n, {KeyCode, Released, Extended}, {mKey, mRel, mExtOut});
            end
            if (lastFlagged) begin
                vectors++;
                if (flagCyc - stopFallCyc !== LATENCY) begin
                    miscompares++; $display("FAIL rand%0d_latency got %0d exp %0d", n, flagCyc - stopFallCyc, LATENCY);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefixes();
        test_parity_error();
        test_timeout();
        test_glitch_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
